cp0_regs: RTL and testbench
===========================

# cp0_regs

Coprocessor-0 register file for the MIPS pipeline. It holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId, and serves mfc0 reads and W-stage mtc0 writes. It consumes the M-stage exception type from the exception decoder and commits exception entry and eret side effects. It drives cp0_statusW, cp0_causeW and cp0_epcW back to that decoder, and generates the timer interrupt.

## Interface
- PRID, default 32'h0000_4220: read-only PRId value.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- we_i  in  1  mtc0 write enable (W stage).
- waddr_i  in  5  write register number (`CP0_REG_*` from defines2.vh).
- wdata_i  in  32  write data.
- raddr_i  in  5  mfc0 read register number.
- int_i  in  6  external hardware interrupts, level sensitive.
- excepttype_i  in  32  exception code from the M stage (0 = none).
- current_inst_addr_i  in  32  PC of the M-stage instruction.
- is_in_delayslot_i  in  1  M-stage instruction is in a delay slot.
- bad_addr_i  in  32  faulting address for AdEL/AdES.
- rdata_o  out  32  read data, combinational.
- count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  out  32 each  register contents.
- timer_int_o  out  1  timer interrupt pending.

## Operation
- Reset values:
  - Count, Compare, Cause, EPC, BadVAddr and timer_int_o reset to 0.
  - Status resets to 32'h0040_0000 (BEV=1).
  - The internal Count toggle bit resets to 0.
- Read: rdata_o selects BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13), EPC (14) or PRId (15) by raddr_i. Any other address reads 0. There is no write-to-read bypass.
- Count: a toggle bit flips every cycle. Count increments by 1 (mod 2^32, wraps silently) on cycles where the toggle is 1, i.e. at half clock rate.
- Timer: when Compare != 0 and Count == Compare (registered values), timer_int_o is set to 1. It stays set until Compare is written.
- Cause[15:10] is loaded every cycle with {int_i[5] | timer_int_o, int_i[4:0]}.
- mtc0 writes, applied when we_i=1:
  - Count: all 32 bits; the toggle bit is also cleared.
  - Compare: all 32 bits; timer_int_o is cleared.
  - Status: all 32 bits.
  - Cause: bits [9:8] only.
  - EPC: all 32 bits.
  - BadVAddr and PRId are read-only; writes are ignored.
- Exception entry, for excepttype_i of 1, 4, 5, 8, 9, 0xa or 0xc:
  - ExcCode Cause[6:2] is set to 0x00 (int), 0x04 (AdEL), 0x05 (AdES), 0x08 (Sys), 0x09 (Bp), 0x0a (RI) or 0x0c (Ov) respectively.
  - If Status[1] (EXL) was 0: EPC <= is_in_delayslot_i ? current_inst_addr_i − 4 : current_inst_addr_i, and Cause[31] (BD) <= is_in_delayslot_i.
  - If EXL was already 1, EPC and BD are unchanged.
  - Status[1] is set to 1.
  - For types 4 and 5 only, BadVAddr <= bad_addr_i.
- eret (excepttype_i = 0xe): Status[1] is cleared. Nothing else changes.
- Any other nonzero excepttype_i value is ignored.

## Timing
- All state updates on posedge clk. rst clears state immediately and asynchronously; it is safe mid-operation, and the counter restarts with toggle = 0.
- Outputs are registered. Each update is visible the cycle after the edge that captures it. rdata_o follows raddr_i combinationally.
- Same-cycle priority is one next-state computation in this order:
  1. mtc0 write is merged first.
  2. Exception or eret field updates override it (EXL, ExcCode, BD, EPC, BadVAddr).
  3. The Cause[15:10] interrupt refresh always wins for those bits.
- Count write vs. increment in the same cycle: the write wins.
- Compare write vs. timer match in the same cycle: the clear wins (timer_int_o = 0).
- The exception decoder forwards the W-stage write itself, so this block requires no internal forwarding.

## Test plan
- Reset and read map: assert rst mid-run.
  - Status = 32'h0040_0000 and all other registers read 0.
  - PRId reads 32'h0000_4220.
  - raddr 5'd3 reads 0.
- Timer: write Compare = 5, then Count = 0.
  - timer_int_o rises when Count reaches 5, about 10 cycles later.
  - Cause[15] = 1 on the following cycle.
  - Writing Compare = 100 clears timer_int_o next cycle.
- Syscall entry: Status = 0, excepttype_i = 8, PC = 32'hbfc0_0100, delayslot = 1.
  - EPC = 32'hbfc0_00fc, Cause[31] = 1, Cause[6:2] = 8, Status[1] = 1.
- Nested and eret:
  - With EXL = 1, excepttype_i = 0xc at PC 32'h1000: ExcCode = 0x0c, EPC unchanged.
  - Then excepttype_i = 0xe: Status[1] = 0.
- AdES with a concurrent mtc0 EPC = 32'h1234 and bad_addr_i = 32'h8000_0003:
  - EPC = current_inst_addr_i (exception wins).
  - BadVAddr = 32'h8000_0003.
- Cause write mask: mtc0 Cause = 32'hffff_ffff with int_i = 0.
  - Cause reads 32'h0000_0300.

Source files
------------

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, BadVAddr, PRId.
// Merges mtc0 writes, exception entry/eret side effects and interrupt sampling into one update.
module cp0_regs #(
   parameter logic [31:0] PRID = 32'h0000_4220
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] current_inst_addr_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] bad_addr_i,
   output logic [31:0] rdata_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic [31:0] badvaddr_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;

   localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
   localparam logic [31:0] EXC_ERET     = 32'h0000_000e;

   logic        toggle, toggle_n;
   logic [31:0] count_n, compare_n, status_n, cause_n, epc_n, badvaddr_n;
   logic        timer_n;
   logic        is_exc;
   logic [4:0]  exc_code;

   // Exception decode: which excepttype values trigger entry and the ExcCode they record.
   always_comb begin
      is_exc   = 1'b1;
      exc_code = 5'h00;
      case (excepttype_i)
         32'h1:   exc_code = 5'h00;
         32'h4:   exc_code = 5'h04;
         32'h5:   exc_code = 5'h05;
         32'h8:   exc_code = 5'h08;
         32'h9:   exc_code = 5'h09;
         32'ha:   exc_code = 5'h0a;
         32'hc:   exc_code = 5'h0c;
         default: is_exc   = 1'b0;
      endcase
   end

   // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      toggle_n   = ~toggle;
      count_n    = toggle ? count_o + 32'd1 : count_o;
      compare_n  = compare_o;
      status_n   = status_o;
      cause_n    = cause_o;
      epc_n      = epc_o;
      badvaddr_n = badvaddr_o;
      timer_n    = timer_int_o | ((compare_o != 32'd0) && (count_o == compare_o));

      if (we_i) begin
         case (waddr_i)
            REG_COUNT: begin
               count_n  = wdata_i;
               toggle_n = 1'b0;
            end
            REG_COMPARE: begin
               compare_n = wdata_i;
               timer_n   = 1'b0;
            end
            REG_STATUS: status_n      = wdata_i;
            REG_CAUSE:  cause_n[9:8]  = wdata_i[9:8];
            REG_EPC:    epc_n         = wdata_i;
            default: ;
         endcase
      end

      // Exception side effects override the mtc0 merge; EXL is judged on the registered Status.
      if (is_exc) begin
         cause_n[6:2] = exc_code;
         if (!status_o[1]) begin
            epc_n       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
            cause_n[31] = is_in_delayslot_i;
         end
         status_n[1] = 1'b1;
         if (excepttype_i == 32'h4 || excepttype_i == 32'h5)
            badvaddr_n = bad_addr_i;
      end else if (excepttype_i == EXC_ERET) begin
         status_n[1] = 1'b0;
      end

      cause_n[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
   end

   // NOTE: sequential state uses non-blocking assignments only; combinational logic above uses blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle      <= 1'b0;
         count_o     <= 32'd0;
         compare_o   <= 32'd0;
         status_o    <= STATUS_RESET;
         cause_o     <= 32'd0;
         epc_o       <= 32'd0;
         badvaddr_o  <= 32'd0;
         timer_int_o <= 1'b0;
      end else begin
         toggle      <= toggle_n;
         count_o     <= count_n;
         compare_o   <= compare_n;
         status_o    <= status_n;
         cause_o     <= cause_n;
         epc_o       <= epc_n;
         badvaddr_o  <= badvaddr_n;
         timer_int_o <= timer_n;
      end
   end

   always_comb begin
      rdata_o = 32'd0;
      case (raddr_i)
         REG_BADVADDR: rdata_o = badvaddr_o;
         REG_COUNT:    rdata_o = count_o;
         REG_COMPARE:  rdata_o = compare_o;
         REG_STATUS:   rdata_o = status_o;
         REG_CAUSE:    rdata_o = cause_o;
         REG_EPC:      rdata_o = epc_o;
         REG_PRID:     rdata_o = PRID;
         default:      rdata_o = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: expectations queued per scenario, drained through the read port.
module tb_cp0_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic [4:0]  raddr_i;
   logic [5:0]  int_i;
   logic [31:0] excepttype_i;
   logic [31:0] current_inst_addr_i;
   logic        is_in_delayslot_i;
   logic [31:0] bad_addr_i;
   logic [31:0] rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
   logic        timer_int_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [4:0]  addr;
      logic [31:0] mask;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];

   cp0_regs #(.PRID(32'h0000_4220)) dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
      .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
      .bad_addr_i(bad_addr_i), .rdata_o(rdata_o), .count_o(count_o), .compare_o(compare_o),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
      .timer_int_o(timer_int_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_reg(input string name, input logic [4:0] addr,
                             input logic [31:0] mask, input logic [31:0] value);
      exp_t e;
      e.name = name; e.addr = addr; e.mask = mask; e.value = value;
      sb.push_back(e);
   endtask

   // Pops every queued expectation, reads it through rdata_o and through the dedicated output.
   task automatic drain();
      exp_t e;
      logic [31:0] direct;
      bit has_direct;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         raddr_i = e.addr;
         #1;
         checks++;
         if ((rdata_o & e.mask) !== e.value) begin
            errors++;
            $display("FAIL %s: rdata=%h (masked %h) expected %h", e.name, rdata_o, rdata_o & e.mask, e.value);
         end
         has_direct = 1'b1;
         direct = 32'd0;
         case (e.addr)
            5'd8:    direct = badvaddr_o;
            5'd9:    direct = count_o;
            5'd11:   direct = compare_o;
            5'd12:   direct = status_o;
            5'd13:   direct = cause_o;
            5'd14:   direct = epc_o;
            default: has_direct = 1'b0;
         endcase
         if (has_direct) begin
            checks++;
            if ((direct & e.mask) !== e.value) begin
               errors++;
               $display("FAIL %s_port: output=%h expected %h", e.name, direct & e.mask, e.value);
            end
         end
      end
   endtask

   task automatic check_timer(input string name, input logic value);
      checks++;
      if (timer_int_o !== value) begin
         errors++;
         $display("FAIL %s: timer_int_o=%b expected %b", name, timer_int_o, value);
      end
   endtask

   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      we_i = 1'b1; waddr_i = addr; wdata_i = data;
      step();
      we_i = 1'b0;
   endtask

   task automatic exc(input logic [31:0] etype, input logic [31:0] pc, input logic ds,
                      input logic [31:0] bad);
      excepttype_i = etype; current_inst_addr_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
      step();
      excepttype_i = 32'd0;
   endtask

   task automatic test_reset();
      wr(5'd12, 32'hdead_beef);
      wr(5'd14, 32'h1234_5678);
      wr(5'd11, 32'h0000_0003);
      repeat (3) step();
      #2 rst = 1'b1;
      #1;
      expect_reg("rst_badvaddr", 5'd8,  32'hffff_ffff, 32'd0);
      expect_reg("rst_count",    5'd9,  32'hffff_ffff, 32'd0);
      expect_reg("rst_compare",  5'd11, 32'hffff_ffff, 32'd0);
      expect_reg("rst_status",   5'd12, 32'hffff_ffff, 32'h0040_0000);
      expect_reg("rst_cause",    5'd13, 32'hffff_ffff, 32'd0);
      expect_reg("rst_epc",      5'd14, 32'hffff_ffff, 32'd0);
      expect_reg("rst_prid",     5'd15, 32'hffff_ffff, 32'h0000_4220);
      expect_reg("rst_unmapped", 5'd3,  32'hffff_ffff, 32'd0);
      drain();
      check_timer("rst_timer", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_cause_mask();
      wr(5'd13, 32'hffff_ffff);
      expect_reg("cause_write_mask", 5'd13, 32'hffff_ffff, 32'h0000_0300);
      drain();
      int_i = 6'h15;
      step();
      expect_reg("cause_int_refresh", 5'd13, 32'h0000_fc00, 32'h0000_5400);
      drain();
      int_i = 6'h00;
      step();
   endtask

   task automatic test_count();
      // Toggle restarts at 0 on a Count write, so increments land on every second edge.
      wr(5'd9, 32'hffff_fffe);
      step();
      expect_reg("count_hold", 5'd9, 32'hffff_ffff, 32'hffff_fffe);
      drain();
      step();
      expect_reg("count_inc", 5'd9, 32'hffff_ffff, 32'hffff_ffff);
      drain();
      step(); step();
      expect_reg("count_wrap", 5'd9, 32'hffff_ffff, 32'h0000_0000);
      drain();
      step();
      wr(5'd9, 32'h0000_0042);
      expect_reg("count_write_wins", 5'd9, 32'hffff_ffff, 32'h0000_0042);
      drain();
   endtask

   task automatic test_timer();
      wr(5'd9, 32'd0);
      wr(5'd11, 32'd5);
      wr(5'd9, 32'd0);
      repeat (10) step();
      expect_reg("timer_count_at_5", 5'd9, 32'hffff_ffff, 32'd5);
      drain();
      check_timer("timer_before_match", 1'b0);
      step();
      check_timer("timer_rise", 1'b1);
      step();
      expect_reg("timer_cause15", 5'd13, 32'h0000_8000, 32'h0000_8000);
      drain();
      repeat (4) step();
      check_timer("timer_sticky", 1'b1);
      wr(5'd11, 32'd100);
      check_timer("timer_clear", 1'b0);
      expect_reg("compare_val", 5'd11, 32'hffff_ffff, 32'd100);
      drain();
   endtask

   task automatic test_syscall();
      wr(5'd12, 32'd0);
      exc(32'h8, 32'hbfc0_0100, 1'b1, 32'd0);
      expect_reg("sys_epc",    5'd14, 32'hffff_ffff, 32'hbfc0_00fc);
      expect_reg("sys_bd_exc", 5'd13, 32'h8000_007c, 32'h8000_0020);
      expect_reg("sys_exl",    5'd12, 32'hffff_ffff, 32'h0000_0002);
      drain();
   endtask

   task automatic test_nested_eret();
      exc(32'hc, 32'h0000_1000, 1'b0, 32'd0);
      expect_reg("nest_exccode", 5'd13, 32'h8000_007c, 32'h8000_0030);
      expect_reg("nest_epc",     5'd14, 32'hffff_ffff, 32'hbfc0_00fc);
      drain();
      exc(32'he, 32'h0000_2000, 1'b0, 32'd0);
      expect_reg("eret_status", 5'd12, 32'hffff_ffff, 32'h0000_0000);
      expect_reg("eret_epc",    5'd14, 32'hffff_ffff, 32'hbfc0_00fc);
      drain();
      exc(32'h3, 32'h0000_3000, 1'b0, 32'h5555_5555);
      expect_reg("ignored_status", 5'd12, 32'hffff_ffff, 32'h0000_0000);
      expect_reg("ignored_cause",  5'd13, 32'h8000_007c, 32'h8000_0030);
      drain();
   endtask

   task automatic test_back_to_back();
      we_i = 1'b1; waddr_i = 5'd14; wdata_i = 32'h0000_1234;
      exc(32'h5, 32'h0000_2000, 1'b0, 32'h8000_0003);
      we_i = 1'b0;
      expect_reg("ades_epc",      5'd14, 32'hffff_ffff, 32'h0000_2000);
      expect_reg("ades_badvaddr", 5'd8,  32'hffff_ffff, 32'h8000_0003);
      expect_reg("ades_cause",    5'd13, 32'h8000_007c, 32'h0000_0014);
      drain();
      wr(5'd8, 32'h0bad_0bad);
      wr(5'd15, 32'h0bad_0bad);
      expect_reg("ro_badvaddr", 5'd8,  32'hffff_ffff, 32'h8000_0003);
      expect_reg("ro_prid",     5'd15, 32'hffff_ffff, 32'h0000_4220);
      drain();
   endtask

   initial begin
      rst = 1'b1; we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0; raddr_i = 5'd0;
      int_i = 6'd0; excepttype_i = 32'd0; current_inst_addr_i = 32'd0;
      is_in_delayslot_i = 1'b0; bad_addr_i = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      test_reset();
      test_cause_mask();
      test_count();
      test_timer();
      test_syscall();
      test_nested_eret();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
